// File: rtl/hv_efuse_loader.sv
// hv_efuse_loader
// Responder for the efuse load handshake. On a level request it walks the
// efuse macro word by word with timed read pulses, copies every word into the
// shadow register file and answers with done plus a validity flag.
//
// Optional build macro: HV_EFUSE_CRC_CHK_EN
//   defined     - the last word is an XOR checksum of the others; o_efuse_vld
//                 reports whether the XOR of all words is zero.
//   not defined - o_efuse_vld is set on every completed load, no accumulator.
//
// Every output is a register loaded with the value that belongs to the state
// being entered. This keeps the macro strobes and the shadow write glitch-free.

module hv_efuse_loader #(
    parameter int EFUSE_WORD_NUM = 8,   // words per load, >= 2
    parameter int EFUSE_DW       = 8,   // efuse word width
    parameter int EFUSE_AW       = 3,   // 2**EFUSE_AW >= EFUSE_WORD_NUM
    parameter int RD_PULSE_CYC   = 4,   // cycles rden is held high per word, >= 1
    parameter int SETTLE_CYC     = 2    // cycles after rden falls before sampling, >= 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_efuse_load_req,
    output logic                o_efuse_load_done,
    output logic                o_efuse_vld,
    output logic                o_busy,
    output logic [EFUSE_AW-1:0] o_efuse_addr,
    output logic                o_efuse_rden,
    input  logic [EFUSE_DW-1:0] i_efuse_rdata,
    output logic                o_efuse_wr_en,
    output logic [EFUSE_AW-1:0] o_efuse_wr_addr,
    output logic [EFUSE_DW-1:0] o_efuse_wr_data
);

    // One shared cycle counter serves both timed phases, so it is sized for
    // the longer of the two.
    localparam int CNT_MAX = (RD_PULSE_CYC > SETTLE_CYC) ? RD_PULSE_CYC : SETTLE_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]    RD_LAST   = CNT_W'(RD_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]    SET_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [EFUSE_AW-1:0] ADDR_LAST = EFUSE_AW'(EFUSE_WORD_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_PULSE = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t                state_reg;
    logic [CNT_W-1:0]      cyc_cnt_reg;
    logic [EFUSE_AW-1:0]   addr_reg;
    logic                  rden_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  vld_reg;
    logic                  wr_en_reg;
    logic [EFUSE_AW-1:0]   wr_addr_reg;
    logic [EFUSE_DW-1:0]   wr_data_reg;

`ifdef HV_EFUSE_CRC_CHK_EN
    // Running XOR of every word captured during the current load.
    logic [EFUSE_DW-1:0]   acc_reg;
    logic [EFUSE_DW-1:0]   acc_next;
    logic                  crc_ok;

    // Fold in the word being captured this edge.
    assign acc_next = acc_reg ^ i_efuse_rdata;
    // acc_reg already holds all words when the last CAPTURE exits to DONE.
    assign crc_ok   = (acc_reg == '0);
`endif

    // Load sequencer: state, counters and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            cyc_cnt_reg <= '0;
            addr_reg    <= '0;
            rden_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            vld_reg     <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
`ifdef HV_EFUSE_CRC_CHK_EN
            acc_reg     <= '0;
`endif
        end else begin
            // The shadow write strobe is a single-cycle pulse.
            wr_en_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    rden_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (i_efuse_load_req) begin
                        // Every request performs a complete reload from word 0.
                        state_reg   <= ST_RD_PULSE;
                        cyc_cnt_reg <= '0;
                        addr_reg    <= '0;
                        rden_reg    <= 1'b1;
                        busy_reg    <= 1'b1;
                        vld_reg     <= 1'b0;
`ifdef HV_EFUSE_CRC_CHK_EN
                        acc_reg     <= '0;
`endif
                    end
                end

                ST_RD_PULSE: begin
                    if (!i_efuse_load_req) begin
                        // Abort: drop the strobe, keep done and vld low.
                        state_reg   <= ST_IDLE;
                        cyc_cnt_reg <= '0;
                        rden_reg    <= 1'b0;
                        busy_reg    <= 1'b0;
                    end else if (cyc_cnt_reg == RD_LAST) begin
                        state_reg   <= ST_SETTLE;
                        cyc_cnt_reg <= '0;
                        rden_reg    <= 1'b0;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
                    end
                end

                ST_SETTLE: begin
                    if (!i_efuse_load_req) begin
                        state_reg   <= ST_IDLE;
                        cyc_cnt_reg <= '0;
                        busy_reg    <= 1'b0;
                    end else if (cyc_cnt_reg == SET_LAST) begin
                        // Request is checked on the same edge that takes the
                        // word, so a dropped request never produces a write.
                        state_reg   <= ST_CAPTURE;
                        cyc_cnt_reg <= '0;
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= addr_reg;
                        wr_data_reg <= i_efuse_rdata;
`ifdef HV_EFUSE_CRC_CHK_EN
                        acc_reg     <= acc_next;
`endif
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
                    end
                end

                ST_CAPTURE: begin
                    if (!i_efuse_load_req) begin
                        state_reg   <= ST_IDLE;
                        cyc_cnt_reg <= '0;
                        busy_reg    <= 1'b0;
                    end else if (addr_reg == ADDR_LAST) begin
                        // Last word stored: publish completion and validity.
                        state_reg   <= ST_DONE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
`ifdef HV_EFUSE_CRC_CHK_EN
                        vld_reg     <= crc_ok;
`else
                        vld_reg     <= 1'b1;
`endif
                    end else begin
                        // Address stops at the last word, it never wraps.
                        state_reg   <= ST_RD_PULSE;
                        cyc_cnt_reg <= '0;
                        addr_reg    <= addr_reg + EFUSE_AW'(1);
                        rden_reg    <= 1'b1;
                    end
                end

                ST_DONE: begin
                    // Hold done for as long as the requester keeps req high;
                    // vld survives the return to IDLE.
                    if (!i_efuse_load_req) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg   <= ST_IDLE;
                    cyc_cnt_reg <= '0;
                    rden_reg    <= 1'b0;
                    busy_reg    <= 1'b0;
                    done_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign o_efuse_load_done = done_reg;
    assign o_efuse_vld       = vld_reg;
    assign o_busy            = busy_reg;
    assign o_efuse_addr      = addr_reg;
    assign o_efuse_rden      = rden_reg;
    assign o_efuse_wr_en     = wr_en_reg;
    assign o_efuse_wr_addr   = wr_addr_reg;
    assign o_efuse_wr_data   = wr_data_reg;

endmodule
